// File: rtl/nn_pass_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : nn_pass_scheduler
// Purpose  : Sequencer in front of the nn forward-pass core. Buffers operand
//            pairs in a FIFO, waits for the core's post-reset weight load,
//            issues one-cycle enable pulses with stable operands, captures the
//            core result after its fixed latency into a valid/ready output
//            register, and keeps saturating pass/overflow statistics.
// Ports    : clk, resetn (async active-low)
//            in_valid/in_ready, in_data_1/2       : request stream
//            nn_enable, nn_input_1/2              : start pulse and operands
//            nn_final_output, nn_total_ovf/zero,
//            nn_ovf/zero_fsm_stage                : core results
//            out_valid/out_ready, out_result,
//            out_ovf/zero, out_ovf/zero_stage     : captured result
//            busy, pass_count, ovf_count          : status and statistics
// Revision : 1.0 - initial release
// ============================================================================
module nn_pass_scheduler #(
  parameter int DATAWIDTH   = 32,
  parameter int DEPTH       = 4,
  parameter int LOAD_CYCLES = 10,
  parameter int LATENCY     = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data_1,
  input  logic [DATAWIDTH-1:0] in_data_2,
  output logic                 nn_enable,
  output logic [DATAWIDTH-1:0] nn_input_1,
  output logic [DATAWIDTH-1:0] nn_input_2,
  input  logic [DATAWIDTH-1:0] nn_final_output,
  input  logic                 nn_total_ovf,
  input  logic                 nn_total_zero,
  input  logic [2:0]           nn_ovf_fsm_stage,
  input  logic [2:0]           nn_zero_fsm_stage,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_result,
  output logic                 out_ovf,
  output logic                 out_zero,
  output logic [2:0]           out_ovf_stage,
  output logic [2:0]           out_zero_stage,
  output logic                 busy,
  output logic [15:0]          pass_count,
  output logic [15:0]          ovf_count
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_MAX = (LOAD_CYCLES > LATENCY) ? LOAD_CYCLES : LATENCY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] C_FULL      = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] C_LOAD_LAST = TMR_W'(LOAD_CYCLES - 1);
  localparam logic [TMR_W-1:0] C_LAT_LAST  = TMR_W'(LATENCY);
  localparam logic [15:0]      C_SAT       = 16'hFFFF;

  typedef enum logic [1:0] {
    S_WAIT_LOAD   = 2'd0,
    S_IDLE        = 2'd1,
    S_ISSUE       = 2'd2,
    S_WAIT_RESULT = 2'd3
  } state_t;

  // FIFO storage is not reset: every entry is written before it can be read.
  logic [DATAWIDTH-1:0] mem1_q [DEPTH];
  logic [DATAWIDTH-1:0] mem2_q [DEPTH];

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 nn_enable_q, nn_enable_d;
  logic [DATAWIDTH-1:0] nn_in1_q, nn_in1_d;
  logic [DATAWIDTH-1:0] nn_in2_q, nn_in2_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATAWIDTH-1:0] out_result_q, out_result_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 out_zero_q, out_zero_d;
  logic [2:0]           out_ovf_stage_q, out_ovf_stage_d;
  logic [2:0]           out_zero_stage_q, out_zero_stage_d;
  logic                 busy_q, busy_d;
  logic [15:0]          pass_count_q, pass_count_d;
  logic [15:0]          ovf_count_q, ovf_count_d;

  logic push;
  logic pop;
  logic capture;

  assign in_ready = (count_q != C_FULL);
  assign push     = in_valid && in_ready;
  // An unconsumed result blocks the next issue, so back-pressure stalls the core.
  assign pop      = (state_q == S_IDLE) && (count_q != '0) && !out_valid_q;
  // Timer restarts at zero on entry, so this is the (LATENCY+1)th edge after E0.
  assign capture  = (state_q == S_WAIT_RESULT) && (tmr_q == C_LAT_LAST);

  always_comb begin
    state_d          = state_q;
    tmr_d            = tmr_q;
    nn_enable_d      = 1'b0;
    nn_in1_d         = nn_in1_q;
    nn_in2_d         = nn_in2_q;
    out_valid_d      = out_valid_q;
    out_result_d     = out_result_q;
    out_ovf_d        = out_ovf_q;
    out_zero_d       = out_zero_q;
    out_ovf_stage_d  = out_ovf_stage_q;
    out_zero_stage_d = out_zero_stage_q;
    pass_count_d     = pass_count_q;
    ovf_count_d      = ovf_count_q;

    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_WAIT_LOAD: begin
        if (tmr_q == C_LOAD_LAST) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_IDLE: begin
        if (pop) begin
          state_d     = S_ISSUE;
          nn_enable_d = 1'b1;
          nn_in1_d    = mem1_q[rd_ptr_q];
          nn_in2_d    = mem2_q[rd_ptr_q];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_RESULT;
        tmr_d   = '0;
      end
      S_WAIT_RESULT: begin
        if (capture) begin
          state_d          = S_IDLE;
          tmr_d            = '0;
          out_valid_d      = 1'b1;
          out_result_d     = nn_final_output;
          out_ovf_d        = nn_total_ovf;
          out_zero_d       = nn_total_zero;
          out_ovf_stage_d  = nn_ovf_fsm_stage;
          out_zero_stage_d = nn_zero_fsm_stage;
          if (pass_count_q != C_SAT) begin
            pass_count_d = pass_count_q + 16'd1;
          end
          if (nn_total_ovf && (ovf_count_q != C_SAT)) begin
            ovf_count_d = ovf_count_q + 16'd1;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_WAIT_LOAD;
    endcase

    // Registered so that busy reads 0 while held in reset, yet still
    // reflects WAIT_LOAD as busy from the first edge afterwards.
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem1_q[wr_ptr_q] <= in_data_1;
      mem2_q[wr_ptr_q] <= in_data_2;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= S_WAIT_LOAD;
      tmr_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      nn_enable_q      <= 1'b0;
      nn_in1_q         <= '0;
      nn_in2_q         <= '0;
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_ovf_q        <= 1'b0;
      out_zero_q       <= 1'b0;
      out_ovf_stage_q  <= '0;
      out_zero_stage_q <= '0;
      busy_q           <= 1'b0;
      pass_count_q     <= '0;
      ovf_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      tmr_q            <= tmr_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      nn_enable_q      <= nn_enable_d;
      nn_in1_q         <= nn_in1_d;
      nn_in2_q         <= nn_in2_d;
      out_valid_q      <= out_valid_d;
      out_result_q     <= out_result_d;
      out_ovf_q        <= out_ovf_d;
      out_zero_q       <= out_zero_d;
      out_ovf_stage_q  <= out_ovf_stage_d;
      out_zero_stage_q <= out_zero_stage_d;
      busy_q           <= busy_d;
      pass_count_q     <= pass_count_d;
      ovf_count_q      <= ovf_count_d;
    end
  end

  assign nn_enable      = nn_enable_q;
  assign nn_input_1     = nn_in1_q;
  assign nn_input_2     = nn_in2_q;
  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_ovf        = out_ovf_q;
  assign out_zero       = out_zero_q;
  assign out_ovf_stage  = out_ovf_stage_q;
  assign out_zero_stage = out_zero_stage_q;
  assign busy           = busy_q;
  assign pass_count     = pass_count_q;
  assign ovf_count      = ovf_count_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_pass_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_pass_scheduler
// Purpose  : Scoreboard bench for nn_pass_scheduler with a behavioural nn core
//            stub whose outputs are only correct LATENCY edges after enable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_pass_scheduler;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LC    = 10;
  localparam int LAT   = 5;

  typedef struct {
    logic [DW-1:0] a, b, res;
    logic          ovf, zero;
    logic [2:0]    os, zs;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data_1 = '0, in_data_2 = '0;
  logic          out_ready = 1'b1;
  logic          in_ready, nn_enable, out_valid, out_ovf, out_zero, busy;
  logic [DW-1:0] nn_input_1, nn_input_2, nn_final_output, out_result;
  logic          nn_total_ovf, nn_total_zero;
  logic [2:0]    nn_ovf_fsm_stage, nn_zero_fsm_stage, out_ovf_stage, out_zero_stage;
  logic [15:0]   pass_count, ovf_count;

  always #5 clk = ~clk;

  nn_pass_scheduler #(.DATAWIDTH(DW), .DEPTH(DEPTH), .LOAD_CYCLES(LC), .LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_1(in_data_1), .in_data_2(in_data_2), .nn_enable(nn_enable),
    .nn_input_1(nn_input_1), .nn_input_2(nn_input_2), .nn_final_output(nn_final_output),
    .nn_total_ovf(nn_total_ovf), .nn_total_zero(nn_total_zero),
    .nn_ovf_fsm_stage(nn_ovf_fsm_stage), .nn_zero_fsm_stage(nn_zero_fsm_stage),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ovf(out_ovf), .out_zero(out_zero), .out_ovf_stage(out_ovf_stage),
    .out_zero_stage(out_zero_stage), .busy(busy), .pass_count(pass_count),
    .ovf_count(ovf_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour of the nn core: sum with signed-overflow flag.
  function automatic exp_t core_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.a    = a;
    e.b    = b;
    e.res  = a + b;
    e.ovf  = (a[DW-1] == b[DW-1]) && (e.res[DW-1] != a[DW-1]);
    e.zero = (e.res == '0);
    e.os   = a[2:0];
    e.zs   = b[2:0] ^ 3'd5;
    return e;
  endfunction

  function automatic logic [63:0] sat16(input int v);
    return (v > 65535) ? 64'hFFFF : 64'(v);
  endfunction

  // ---------------- nn core stub: garbage until LATENCY edges after enable
  logic [DW-1:0] stub_a = '0, stub_b = '0;
  int            stub_cd = 0;
  exp_t          stub_e;
  always @(posedge clk) begin
    if (nn_enable) begin
      stub_a  <= nn_input_1;
      stub_b  <= nn_input_2;
      stub_cd <= LAT;
    end else if (stub_cd > 0) begin
      stub_cd <= stub_cd - 1;
    end
  end
  always_comb begin
    stub_e = core_ref(stub_a, stub_b);
    if (stub_cd == 0) begin
      nn_final_output   = stub_e.res;
      nn_total_ovf      = stub_e.ovf;
      nn_total_zero     = stub_e.zero;
      nn_ovf_fsm_stage  = stub_e.os;
      nn_zero_fsm_stage = stub_e.zs;
    end else begin
      nn_final_output   = ~stub_e.res;
      nn_total_ovf      = ~stub_e.ovf;
      nn_total_zero     = ~stub_e.zero;
      nn_ovf_fsm_stage  = ~stub_e.os;
      nn_zero_fsm_stage = ~stub_e.zs;
    end
  end

  // ---------------- scoreboard / monitor
  exp_t          q_issue[$];
  exp_t          q_out[$];
  int            n_en = 0, n_out = 0, n_ovf = 0, n_caps = 0, n_ov_rise = 0;
  int            en_cyc = 0, first_en_cyc = -1, hs_cyc = 0;
  int            pass_offset = 0;
  logic          prev_en = 1'b0, prev_ov = 1'b0, prev_rdy = 1'b0;
  logic [DW-1:0] prev_res = '0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!resetn) begin
      q_issue.delete();
      q_out.delete();
      prev_en      = 1'b0;
      prev_ov      = 1'b0;
      first_en_cyc = -1;
      n_caps       = 0;
      n_ovf        = 0;
    end else begin
      if (nn_enable) begin
        n_en++;
        en_cyc = cyc;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        chk("enable_single_cycle", prev_en, 0);
        if (q_issue.size() == 0) begin
          chk("issue_without_request", nn_enable, 0);
        end else begin
          e = q_issue.pop_front();
          chk("issue_op1", nn_input_1, e.a);
          chk("issue_op2", nn_input_2, e.b);
        end
      end
      prev_en = nn_enable;
      if (out_valid && !prev_ov) begin
        n_ov_rise++;
        chk("result_latency", 64'(cyc - en_cyc), 64'(LAT + 2));
      end
      if (out_valid && prev_ov && !prev_rdy) chk("hold_stable", out_result, prev_res);
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        n_out++;
        n_caps++;
        if (q_out.size() == 0) begin
          chk("unexpected_result", out_valid, 0);
        end else begin
          e = q_out.pop_front();
          if (e.ovf) n_ovf++;
          chk("out_result", out_result, e.res);
          chk("out_ovf", out_ovf, e.ovf);
          chk("out_zero", out_zero, e.zero);
          chk("out_ovf_stage", out_ovf_stage, e.os);
          chk("out_zero_stage", out_zero_stage, e.zs);
          chk("pass_count", pass_count, sat16(pass_offset + n_caps));
          chk("ovf_count", ovf_count, sat16(n_ovf));
        end
      end
      prev_ov  = out_valid;
      prev_rdy = out_ready;
      prev_res = out_result;
      if (in_valid && in_ready) begin
        e = core_ref(in_data_1, in_data_2);
        q_issue.push_back(e);
        q_out.push_back(e);
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic wait_outs(input int target, input int budget);
    int k = 0;
    while (n_out < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_out < target) chk("timeout_results", 64'(n_out), 64'(target));
  endtask

  task automatic push1(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int k = 0;
    in_valid  = 1'b1;
    in_data_1 = a;
    in_data_2 = b;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) chk("timeout_push", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic start_reset();
    resetn      = 1'b0;
    in_valid    = 1'b0;
    pass_offset = 0;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  t0, n0, ne, k, acc;
    bit  ok;
    logic [DW-1:0] held;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nn_enable", nn_enable, 0);
    chk("rst_pass_count", pass_count, 0);

    // ---- load wait and single pass (100,50)
    in_valid = 1'b1; in_data_1 = 100; in_data_2 = 50;
    resetn = 1'b1;
    t0 = cyc; n0 = n_out; ne = n_en;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_outs(n0 + 1, 100);
    chk("first_enable_edge", 64'(first_en_cyc - t0), 64'(LC + 1));
    chk("single_enable", 64'(n_en - ne), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("single_result", out_result, 150);
    chk("single_pass_count", pass_count, 1);
    chk("busy_idle", busy, 0);

    // ---- FIFO full during load
    start_reset();
    resetn = 1'b1;
    n0 = n_out;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data_1 = DW'(i); in_data_2 = DW'(i);
      @(posedge clk); #1;
    end
    chk("full_in_ready", in_ready, 0);
    chk("busy_loading", busy, 1);
    in_data_1 = 5; in_data_2 = 5;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc = cyc;
    chk("fifth_after_pop", 64'(acc - first_en_cyc), 1);
    wait_outs(n0 + 5, 300);

    // ---- back-pressure
    n0 = n_out;
    out_ready = 1'b0;
    push1(7, 8);
    push1(9, 10);
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_first_valid", out_valid, 1);
    held = out_result;
    ne = n_en;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_result !== held || !out_valid) ok = 1'b0;
    end
    chk("bp_stable_20", ok, 1);
    chk("bp_no_issue", 64'(n_en - ne), 0);
    out_ready = 1'b1;
    k = 0;
    while (n_en == ne && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_reissue_gap", 64'(en_cyc - hs_cyc), 2);
    wait_outs(n0 + 2, 100);

    // ---- statistics: ovf pattern 0,1,0
    start_reset();
    resetn = 1'b1;
    n0 = n_out;
    push1(1, 1);
    push1(32'h7FFF_FFFF, 1);
    push1(2, 2);
    wait_outs(n0 + 3, 200);
    chk("stat_pass_count", pass_count, 3);
    chk("stat_ovf_count", ovf_count, 1);

    // ---- randomized traffic with random back-pressure
    for (int i = 0; i < 200; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1);
      in_data_1 = $urandom;
      in_data_2 = ($urandom_range(0, 7) == 0) ? -in_data_1 : DW'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((q_out.size() != 0 || out_valid) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("random_drain", 64'(q_out.size()), 0);

    // ---- pass_count saturation (preloaded near the limit while idle)
    force dut.pass_count_q = 16'hFFFE;
    pass_offset = 16'hFFFE - n_caps;
    @(posedge clk); #1;
    release dut.pass_count_q;
    n0 = n_out;
    push1(11, 12);
    push1(13, 14);
    wait_outs(n0 + 2, 100);
    chk("pass_count_sat", pass_count, 16'hFFFF);

    // ---- reset in the middle of a pass
    ne = n_en;
    push1(3, 4);
    k = 0;
    while (n_en == ne && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    pass_offset = 0;
    #1;
    chk("abort_nn_enable", nn_enable, 0);
    chk("abort_nn_input_1", nn_input_1, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_result", out_result, 0);
    chk("abort_pass_count", pass_count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    k = n_ov_rise;
    repeat (LC + LAT + 10) @(posedge clk);
    #1;
    chk("abort_no_result", 64'(n_ov_rise - k), 0);
    n0 = n_out;
    push1(20, 22);
    wait_outs(n0 + 1, 100);
    chk("after_abort_pass_count", pass_count, 1);
    chk("queues_empty", 64'(q_out.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
